// File: rtl/press_if.sv
// Debounced button events in, classified press events out.
interface press_if;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic       busy;
  logic [1:0] last_event;

  modport master (
    output press_pulse, release_pulse,
    input  short_press, long_press, double_press, held, busy, last_event
  );

  modport slave (
    input  press_pulse, release_pulse,
    output short_press, long_press, double_press, held, busy, last_event
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced press/release pulses into short, long and double presses.
// All outputs are registered; pulses appear in the cycle after the deciding edge.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic   CLK,
  input  logic   RST_N,
  press_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_e;

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;
  logic [1:0]       last_q, last_d;
  logic             press, rel;

  // Simultaneous press and release is a glitch: neither is seen.
  assign press   = bus.press_pulse & ~bus.release_pulse;
  assign rel     = bus.release_pulse & ~bus.press_pulse;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = PRESSED;
      end
      PRESSED: begin
        cnt_d = cnt_inc;
        // Release wins over the long threshold on the same edge.
        if (rel) begin
          state_d = WAIT_SECOND;
          cnt_d   = '0;
        end else if (cnt_inc == LONG_TH) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
          last_d  = 2'b10;
        end
      end
      LONG_HELD: begin
        if (rel) state_d = IDLE;
      end
      WAIT_SECOND: begin
        cnt_d = cnt_inc;
        // A second press wins over gap expiry on the same edge.
        if (press) begin
          state_d = SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == GAP_TH) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
          last_d  = 2'b01;
        end
      end
      SECOND_PRESSED: begin
        cnt_d = cnt_inc;
        if (rel) begin
          state_d  = IDLE;
          cnt_d    = '0;
          double_d = 1'b1;
          last_d   = 2'b11;
        end else if (cnt_inc == LONG_TH) begin
          // Holding the second press still reports a double, never a long.
          state_d  = LONG_HELD;
          cnt_d    = '0;
          double_d = 1'b1;
          last_d   = 2'b11;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    held_d = (state_d == LONG_HELD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.held         = held_q;
  assign bus.busy         = busy_q;
  assign bus.last_event   = last_q;

endmodule

// File: tb/tb_press_classifier.sv
// Table-driven bench for press_classifier with a pulse scoreboard (LONG=8, GAP=5).
module tb_press_classifier;

  localparam logic [2:0] K_S = 3'b001;
  localparam logic [2:0] K_L = 3'b010;
  localparam logic [2:0] K_D = 3'b100;
  localparam int NEDGE = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  press_if bus ();

  press_classifier #(.LONG_CYCLES(8), .GAP_CYCLES(5), .CNT_W(4)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    int         p1, r1, p2, r2, gl, rst_e;
    int         e1;
    logic [2:0] k1;
    int         e2;
    logic [2:0] k2;
    logic [1:0] last;
    logic       busy_end;
    int         busy_lo;
    int         held_from, held_to;
  } vec_t;

  typedef struct {
    int         edge_n;
    logic [2:0] kind;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(string nm, int p1, int r1, int p2, int r2, int gl, int rst_e,
                              int e1, logic [2:0] k1, int e2, logic [2:0] k2, logic [1:0] last,
                              logic busy_end, int busy_lo, int held_from, int held_to);
    vec_t v;
    v.name = nm; v.p1 = p1; v.r1 = r1; v.p2 = p2; v.r2 = r2; v.gl = gl; v.rst_e = rst_e;
    v.e1 = e1; v.k1 = k1; v.e2 = e2; v.k2 = k2; v.last = last; v.busy_end = busy_end;
    v.busy_lo = busy_lo; v.held_from = held_from; v.held_to = held_to;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] all_outs();
    return {bus.short_press, bus.long_press, bus.double_press, bus.held, bus.busy,
            1'b0, bus.last_event};
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t       e;
    logic [2:0] kind;
    logic       exp_held, exp_busy;
    @(negedge clk);
    rst_n = 1'b0;
    bus.press_pulse = 1'b0;
    bus.release_pulse = 1'b0;
    @(posedge clk); #1;
    check({v.name, " reset outs"}, 32'(all_outs()), 32'd0);
    sb.delete();
    if (v.k1 != 3'b000) sb.push_back('{v.e1, v.k1});
    if (v.k2 != 3'b000) sb.push_back('{v.e2, v.k2});
    for (int n = 1; n <= NEDGE; n++) begin
      @(negedge clk);
      rst_n = (n != v.rst_e);
      bus.press_pulse   = (n == v.p1) || (n == v.p2) || (n == v.gl);
      bus.release_pulse = (n == v.r1) || (n == v.r2) || (n == v.gl);
      @(posedge clk); #1;
      kind = {bus.double_press, bus.long_press, bus.short_press};
      if (kind != 3'b000) begin
        if (sb.size() == 0) begin
          check({v.name, " unexpected pulse"}, 32'(kind), 32'd0);
        end else begin
          e = sb.pop_front();
          check({v.name, " pulse kind"}, 32'(kind), 32'(e.kind));
          check({v.name, " pulse edge"}, 32'(n), 32'(e.edge_n));
        end
      end
      exp_held = (v.held_from != 0) && (n >= v.held_from) && (n < v.held_to);
      check({v.name, " held"}, 32'(bus.held), 32'(exp_held));
      if (v.busy_lo != 0) begin
        exp_busy = (v.p1 != 0) && (n >= v.p1) && (n < v.busy_lo);
        check({v.name, " busy"}, 32'(bus.busy), 32'(exp_busy));
      end
    end
    @(negedge clk);
    bus.press_pulse = 1'b0;
    bus.release_pulse = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s missed pulse: got none expected kind %0b at edge %0d",
               v.name, e.kind, e.edge_n);
    end
    check({v.name, " last_event"}, 32'(bus.last_event), 32'(v.last));
    check({v.name, " busy end"}, 32'(bus.busy), 32'(v.busy_end));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.press_pulse = 1'b0;
    bus.release_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("power-on reset", 32'(all_outs()), 32'd0);

    //             name            p1  r1  p2  r2  gl rst  e1  k1   e2  k2   last  be blo hf  ht
    vecs.push_back(mk("short",        10, 13,  0,  0,  0,  0, 17, K_S,  0, 3'b0, 2'b01, 0, 17,  0,  0));
    vecs.push_back(mk("long",         10, 30,  0,  0,  0,  0, 17, K_L,  0, 3'b0, 2'b10, 0, 30, 17, 30));
    vecs.push_back(mk("double",       10, 12, 15, 17,  0,  0, 17, K_D,  0, 3'b0, 2'b11, 0, 17,  0,  0));
    vecs.push_back(mk("rel_at_long",  10, 17,  0,  0,  0,  0, 21, K_S,  0, 3'b0, 2'b01, 0, 21,  0,  0));
    vecs.push_back(mk("press_at_gap", 10, 12, 16, 18,  0,  0, 18, K_D,  0, 3'b0, 2'b11, 0, 18,  0,  0));
    vecs.push_back(mk("glitch_idle",   0,  0,  0,  0, 10,  0,  0, 3'b0, 0, 3'b0, 2'b00, 0,  1,  0,  0));
    vecs.push_back(mk("rst_pressed",  10,  0,  0,  0,  0, 12,  0, 3'b0, 0, 3'b0, 2'b00, 0, 12,  0,  0));
    vecs.push_back(mk("early_press",   2,  4,  0,  0,  0,  0,  8, K_S,  0, 3'b0, 2'b01, 0,  8,  0,  0));
    vecs.push_back(mk("double_long",  10, 12, 15,  0,  0,  0, 22, K_D,  0, 3'b0, 2'b11, 1,  0, 22, 99));
    vecs.push_back(mk("glitch_press", 10,  0,  0,  0, 12,  0, 17, K_L,  0, 3'b0, 2'b10, 1,  0, 17, 99));
    vecs.push_back(mk("ignore_press", 10, 14, 12,  0,  0,  0, 18, K_S,  0, 3'b0, 2'b01, 0, 18,  0,  0));
    vecs.push_back(mk("idle_release",  0,  5,  0,  0,  0,  0,  0, 3'b0, 0, 3'b0, 2'b00, 0,  1,  0,  0));
    vecs.push_back(mk("rst_wait",     10, 12, 20, 22,  0, 14, 26, K_S,  0, 3'b0, 2'b01, 0,  0,  0,  0));
    vecs.push_back(mk("short_long",   10, 12, 20,  0,  0,  0, 16, K_S, 27, K_L,  2'b10, 1,  0, 27, 99));
    vecs.push_back(mk("glitch_wait",  10, 12,  0,  0, 14,  0, 16, K_S,  0, 3'b0, 2'b01, 0, 16,  0,  0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset held across several edges from LONG_HELD: nothing may leak out afterwards.
    @(negedge clk);
    rst_n = 1'b1;
    bus.press_pulse = 1'b1;
    @(negedge clk);
    bus.press_pulse = 1'b0;
    repeat (9) @(negedge clk);
    check("seq held before rst", 32'(bus.held), 32'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("seq outs in rst", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    bus.release_pulse = 1'b1;
    @(negedge clk);
    bus.release_pulse = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("seq quiet after rst", 32'(all_outs()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50000000; the hold duration in CLK cycles that classifies a press as long.
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000; the maximum release-to-press gap in CLK cycles for a double press.
REQ-003 SHALL have parameter CNT_W, default 26; the counter width, with 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port press_pulse, input, 1 bit: one-cycle pulse from the debouncer marking a clean press edge.
REQ-007 SHALL have port release_pulse, input, 1 bit: one-cycle pulse from the debouncer marking a clean release edge.
REQ-008 SHALL have port short_press, output, 1 bit: one-cycle pulse for a classified single short press.
REQ-009 SHALL have port long_press, output, 1 bit: one-cycle pulse for a classified long press.
REQ-010 SHALL have port double_press, output, 1 bit: one-cycle pulse for a classified double press.
REQ-011 SHALL have port held, output, 1 bit: level that is high while in LONG_HELD.
REQ-012 SHALL have port busy, output, 1 bit: level that is high whenever the FSM is not in IDLE.
REQ-013 SHALL have port last_event, output, 2 bits: last classification, where 00 = none, 01 = short, 10 = long, 11 = double.

Function
REQ-014 SHALL implement FSM states IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED, plus a CNT_W-bit counter cnt.
REQ-015 SHALL, in IDLE, go to PRESSED with cnt=0 on press_pulse, and ignore release_pulse.
REQ-016 SHALL, in PRESSED, increment cnt each cycle; release_pulse goes to WAIT_SECOND with cnt=0, and cnt reaching LONG_CYCLES-1 with no release goes to LONG_HELD and pulses long_press.
REQ-017 SHALL, in LONG_HELD, hold held=1 and emit no further pulses; release_pulse returns the FSM to IDLE.
REQ-018 SHALL, in WAIT_SECOND, increment cnt each cycle; press_pulse goes to SECOND_PRESSED with cnt=0, and cnt reaching GAP_CYCLES-1 with no press pulses short_press and returns to IDLE.
REQ-019 SHALL, in SECOND_PRESSED, pulse double_press and return to IDLE on release_pulse, or pulse double_press and go to LONG_HELD when cnt reaches LONG_CYCLES-1; long_press SHALL NOT fire in this case.
REQ-020 SHALL register all outputs; a pulse SHALL be high exactly one cycle, in the cycle after the transition edge.
REQ-021 SHALL have latency such that, with press sampled at edge k and no release, long_press is high during the cycle following edge k+LONG_CYCLES-1.
REQ-022 SHALL have latency such that, with release sampled at edge r and no press, short_press is high during the cycle following edge r+GAP_CYCLES-1.
REQ-023 SHALL give precedence to release_pulse over long classification when both fall on the same threshold edge (short path taken).
REQ-024 SHALL give precedence to press_pulse over short classification when both fall on the gap-expiry edge (double path taken).
REQ-025 SHALL treat press_pulse and release_pulse high in the same cycle as a glitch: both ignored, and state and cnt advance as if neither were asserted.
REQ-026 SHALL ignore press_pulse in PRESSED, LONG_HELD and SECOND_PRESSED, and ignore release_pulse in IDLE and WAIT_SECOND.
REQ-027 SHALL never wrap cnt; cnt is held at 0 in IDLE and LONG_HELD.
REQ-028 SHALL update last_event on the same edge that its pulse is registered; it is never cleared except by reset.
REQ-029 SHALL keep short_press, long_press and double_press mutually exclusive in every cycle.

Reset
REQ-030 SHALL, at any CLK edge with RST_N=0, force state=IDLE, cnt=0, short_press=long_press=double_press=0, held=0, busy=0 and last_event=00.
REQ-031 SHALL, on reset mid-operation (any state), abandon the classification in progress with no pulse emitted, during or after reset.
REQ-032 SHALL, with RST_N returning high at edge j, accept a press_pulse sampled at edge j+1 or later.

Verification (LONG_CYCLES=8, GAP_CYCLES=5, CNT_W=4)
REQ-033 SHALL cover a short press: press at edge 10, release at edge 13 -> short_press high only in the cycle after edge 17; last_event=01; busy low from that cycle on.
REQ-034 SHALL cover a long press: press at edge 10, release at edge 30 -> long_press high only in the cycle after edge 17; held high until the cycle after edge 30; last_event=10.
REQ-035 SHALL cover a double press: press at 10, release at 12, press at 15, release at 17 -> double_press high only in the cycle after edge 17; short_press never asserted; last_event=11.
REQ-036 SHALL cover both boundaries: release exactly at edge 17 after press at 10 -> no long_press, and short_press follows at +5; a second press exactly at the gap-expiry edge -> double path with no short_press.
REQ-037 SHALL cover the glitch and reset cases: press and release together in IDLE -> busy stays 0; RST_N low for one edge while in PRESSED -> all outputs 0 and no pulse ever follows.
